inst_loader: RTL and testbench
==============================

# inst_loader

Boot-time instruction-memory writer for the 16-bit single-cycle processor. It receives a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words from byte pairs. Each word is written into the instruction memory's write port at consecutive 9-bit addresses from 0. It holds the processor (`cpu_hold`) until a frame with a good checksum has been loaded. It is the writer side of the 9-bit-address / 16-bit-data instruction memory that the processor reads.

## Interface
- `HEADER`, 8'hA5, frame start byte.
- `MAX_WORDS`, 512, instruction memory depth; the largest legal word count.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on posedge `clk`.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  one-cycle instruction-memory write strobe.
- `wr_addr`  out  9  write address (word index).
- `wr_data`  out  16  instruction word, {high byte, low byte}.
- `cpu_hold`  out  1  1 = processor PC frozen / in reset.
- `done`  out  1  one-cycle pulse: frame loaded, checksum good.
- `err`  out  1  level: last frame failed; stays high until the next header.

## Operation
- **Frame format:** `HEADER`, CNT_HI, CNT_LO, then N×(word high byte, word low byte), then CHK.
  - N = {CNT_HI, CNT_LO}.
  - CHK = XOR of every byte after `HEADER` (count bytes and data bytes).
- **Byte acceptance:** a byte is accepted on a posedge with `in_valid && in_ready`. When `in_valid` is 0, state does not change.
- **States:** IDLE, CNT_HI, CNT_LO, W_HI, W_LO, CHK, DONE, ERR.
- **IDLE:** `HEADER` → CNT_HI, and `cpu_hold` is set to 1. Any other byte is discarded.
- **CNT_HI:** latch the byte → CNT_LO.
- **CNT_LO:** form N.
  - N == 0 → CHK.
  - N > `MAX_WORDS` → ERR. The check uses the full 16-bit value; 16'h0200 is legal, 16'h0201 is not.
  - Otherwise → W_HI.
- **W_HI:** latch the high byte → W_LO.
- **W_LO:** next cycle, `wr_en` = 1, `wr_data` = {hi, lo}, `wr_addr` = word index. Then increment the word index.
  - If this was word N → CHK.
  - Otherwise → W_HI.
- **CHK:** compare the byte with the running XOR.
  - Match → DONE.
  - Mismatch → ERR.
- **DONE:** lasts one cycle. `done` = 1, `cpu_hold` ← 0, `err` ← 0, `in_ready` = 0. Then → IDLE.
- **ERR:** `err` = 1 and `cpu_hold` stays 1.
  - Non-header bytes are accepted and discarded.
  - `HEADER` clears `err` → CNT_HI.
- **Running state cleared at each header:** running XOR ← 0, word index ← 0.
- **Memory on failure:** words already written before a failed checksum remain in memory. `cpu_hold` staying at 1 is the only protection.
- **Repeated loads:** a later header in IDLE reasserts `cpu_hold` and reloads memory from address 0.
- **Header inside a frame:** `HEADER` bytes inside a frame are treated as data. There is no resynchronisation mid-frame.

## Timing
- **Reset values** (`rst_n` = 0 at posedge): state IDLE, `cpu_hold` = 1, `err` = 0, `done` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `in_ready` = 1, XOR = 0, index = 0.
- **Reset mid-frame** aborts the frame immediately. No further `wr_en` is issued.
- **Registered outputs:** all outputs are registered, and `in_ready` is decoded from the state register.
- **Throughput:** `in_ready` = 1 in every state except DONE, so one byte per cycle is sustained.
- **Write latency:** `wr_en` asserts exactly 1 cycle after the low byte is accepted. `wr_addr` and `wr_data` are held until the next write.
- **Done latency:** `done` and the fall of `cpu_hold` happen 1 cycle after CHK is accepted.
- **Error latency:** `err` rises 1 cycle after a bad CHK byte or a bad CNT_LO byte.
- **Minimum frame time:** a frame of N words takes at least 2N+4 accepted bytes, plus 1 DONE cycle.
- **Stalls:** gaps in `in_valid` between any two bytes are legal and do not change any output.

## Test plan
- **Reset:** assert `rst_n` = 0 for 2 cycles → `cpu_hold` = 1, `err` = 0, `done` = 0, `wr_en` = 0, `in_ready` = 1.
- **Good frame:** send A5 00 02 12 34 AB CD 42, one byte per cycle, no gaps.
  - → `wr_en` pulses with (0, 16'h1234) and then (1, 16'hABCD).
  - → `done` pulses once, 1 cycle after 42 is accepted.
  - → `cpu_hold` = 0, `err` = 0.
- **Bad checksum:** send the same frame with last byte 43.
  - → both writes still occur.
  - → `err` = 1, `cpu_hold` = 1, no `done`.
  - → then send A5 00 00 02 → `err` clears at the header. 02 is a mismatch (00^00 = 00), so `err` = 1 again.
  - → then send A5 00 00 00 → `done`, `cpu_hold` = 0.
- **Oversize count:** send A5 02 01.
  - → ERR 1 cycle after 01 is accepted, no `wr_en` ever.
- **Largest frame:** send A5 02 00, then 512 words with value = index, then the correct XOR.
  - → final write at `wr_addr` = 9'h1FF, `done` = 1.
- **Stall and reset:**
  - Good frame with random `in_valid` gaps → same writes and `done` as with no gaps.
  - Reset pulse after A5 00 02 12 → no writes, state IDLE, `cpu_hold` = 1.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time instruction-memory loader: parses a framed byte stream, writes 16-bit
// words at consecutive addresses and releases cpu_hold once the checksum is good.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for HEADER, other bytes dropped
// S_CNT_HI | expecting word-count high byte
// S_CNT_LO | expecting word-count low byte, range check
// S_W_HI   | expecting instruction high byte
// S_W_LO   | expecting instruction low byte, write issued next cycle
// S_CHK    | expecting checksum byte
// S_DONE   | one-cycle completion, input stalled
// S_ERR    | last frame failed, waiting for HEADER
module inst_loader #(
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter int         MAX_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_W_HI,
    S_W_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t      state, state_nxt;
  logic [7:0]  cnt_hi, cnt_hi_nxt;
  logic [7:0]  hi_byte, hi_byte_nxt;
  logic [8:0]  last_idx, last_idx_nxt;
  logic [8:0]  idx, idx_nxt;
  logic [7:0]  xor_acc, xor_acc_nxt;
  logic        wr_en_nxt;
  logic [8:0]  wr_addr_nxt;
  logic [15:0] wr_data_nxt;
  logic        cpu_hold_nxt;
  logic        done_nxt;
  logic        err_nxt;

  logic        take;
  logic [15:0] count_full;

  assign in_ready   = (state != S_DONE);
  assign take       = in_valid && in_ready;
  assign count_full = {cnt_hi, in_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt_hi   <= 8'h00;
      hi_byte  <= 8'h00;
      last_idx <= 9'h000;
      idx      <= 9'h000;
      xor_acc  <= 8'h00;
      wr_en    <= 1'b0;
      wr_addr  <= 9'h000;
      wr_data  <= 16'h0000;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_hi   <= cnt_hi_nxt;
      hi_byte  <= hi_byte_nxt;
      last_idx <= last_idx_nxt;
      idx      <= idx_nxt;
      xor_acc  <= xor_acc_nxt;
      wr_en    <= wr_en_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      cpu_hold <= cpu_hold_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_hi_nxt   = cnt_hi;
    hi_byte_nxt  = hi_byte;
    last_idx_nxt = last_idx;
    idx_nxt      = idx;
    xor_acc_nxt  = xor_acc;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    cpu_hold_nxt = cpu_hold;
    done_nxt     = 1'b0;
    err_nxt      = err;

    case (state)
      S_IDLE: begin
        if (take && in_data == HEADER) begin
          state_nxt    = S_CNT_HI;
          cpu_hold_nxt = 1'b1;
          err_nxt      = 1'b0;
          xor_acc_nxt  = 8'h00;
          idx_nxt      = 9'h000;
        end
      end
      S_CNT_HI: begin
        if (take) begin
          cnt_hi_nxt  = in_data;
          xor_acc_nxt = xor_acc ^ in_data;
          state_nxt   = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (take) begin
          xor_acc_nxt = xor_acc ^ in_data;
          if (count_full == 16'h0000) begin
            state_nxt = S_CHK;
          end else if (count_full > MAX_CNT) begin
            state_nxt = S_ERR;
            err_nxt   = 1'b1;
          end else begin
            // count is 1..512 here, so count-1 always fits the 9-bit index
            last_idx_nxt = {cnt_hi[0], in_data} - 9'd1;
            state_nxt    = S_W_HI;
          end
        end
      end
      S_W_HI: begin
        if (take) begin
          hi_byte_nxt = in_data;
          xor_acc_nxt = xor_acc ^ in_data;
          state_nxt   = S_W_LO;
        end
      end
      S_W_LO: begin
        if (take) begin
          xor_acc_nxt = xor_acc ^ in_data;
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = idx;
          wr_data_nxt = {hi_byte, in_data};
          idx_nxt     = idx + 9'd1;
          state_nxt   = (idx == last_idx) ? S_CHK : S_W_HI;
        end
      end
      S_CHK: begin
        if (take) begin
          if (in_data == xor_acc) begin
            state_nxt    = S_DONE;
            done_nxt     = 1'b1;
            cpu_hold_nxt = 1'b0;
            err_nxt      = 1'b0;
          end else begin
            state_nxt = S_ERR;
            err_nxt   = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (take && in_data == HEADER) begin
          state_nxt   = S_CNT_HI;
          err_nxt     = 1'b0;
          xor_acc_nxt = 8'h00;
          idx_nxt     = 9'h000;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: frames are built here, and expected writes,
// done and err follow from the frame contents and the checksum rule.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int done_count = 0;
  logic [15:0] words [512];

  inst_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) wr_count++;
      if (done)  done_count++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int w;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check_eq("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] n, input logic [7:0] chk_delta, input bit gaps);
    logic [7:0] x;
    int wr_base, done_base;
    bit good;
    wr_base   = wr_count;
    done_base = done_count;
    send_byte(8'hA5, gaps);
    check_eq("hdr_hold", 32'(cpu_hold), 32'd1);
    check_eq("hdr_err", 32'(err), 32'd0);
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    x = n[15:8] ^ n[7:0];
    if (int'(n) > 512) begin
      check_eq("oversize_err", 32'(err), 32'd1);
      check_eq("oversize_hold", 32'(cpu_hold), 32'd1);
      repeat (3) @(negedge clk);
      check_eq("oversize_writes", 32'(wr_count - wr_base), 32'd0);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      send_byte(words[i][15:8], gaps);
      send_byte(words[i][7:0], gaps);
      x = x ^ words[i][15:8] ^ words[i][7:0];
      check_eq("wr_en", 32'(wr_en), 32'd1);
      check_eq("wr_addr", 32'(wr_addr), 32'(i));
      check_eq("wr_data", 32'(wr_data), 32'(words[i]));
    end
    good = (chk_delta == 8'h00);
    send_byte(x ^ chk_delta, gaps);
    check_eq("done_lat", 32'(done), 32'(good));
    check_eq("chk_hold", 32'(cpu_hold), 32'(!good));
    check_eq("chk_err", 32'(err), 32'(!good));
    @(negedge clk);
    check_eq("done_pulse_end", 32'(done), 32'd0);
    check_eq("frame_writes", 32'(wr_count - wr_base), 32'(n));
    check_eq("frame_dones", 32'(done_count - done_base), 32'(good));
  endtask

  initial begin
    int wb, db;
    // reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_hold", 32'(cpu_hold), 32'd1);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed good frame, then bad checksum and empty frames
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    send_frame(16'h0002, 8'h00, 1'b0);
    send_frame(16'h0002, 8'h01, 1'b0);
    send_frame(16'h0000, 8'h02, 1'b0);
    send_frame(16'h0000, 8'h00, 1'b0);

    // count range boundary
    send_frame(16'h0201, 8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    check_eq("err_discard", 32'(err), 32'd1);
    for (int i = 0; i < 512; i++) words[i] = 16'(i);
    send_frame(16'h0200, 8'h00, 1'b0);

    // random frames with gaps and leading garbage
    for (int t = 0; t < 25; t++) begin
      int n;
      logic [7:0] d;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) words[i] = 16'($urandom);
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom) & 8'h7F, 1'b1);
      send_frame(16'(n), d, 1'b1);
    end

    // reset in the middle of a frame
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    send_frame(16'h0002, 8'h00, 1'b0);
    wb = wr_count;
    db = done_count;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_hold", 32'(cpu_hold), 32'd1);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'h42, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("mid_rst_writes", 32'(wr_count - wb), 32'd0);
    check_eq("mid_rst_dones", 32'(done_count - db), 32'd0);
    check_eq("mid_rst_hold2", 32'(cpu_hold), 32'd1);
    check_eq("mid_rst_err", 32'(err), 32'd0);
    // still in IDLE: a fresh frame must load normally
    send_frame(16'h0002, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
